// File: rtl/npu_job_ctrl.sv
// npu_job_ctrl: host-side job initiator for the NPU core.
// Ports:
//   CLKEXT, RST_GLO        clock and asynchronous active-high reset
//   JOB_*                  job word stream in (valid/ready, 32-bit lane word, last)
//   NPU_START, DA..DD      start pulse and registered operand lanes to the core
//   NPU_BUSY/DONE          core status and completion pulse
//   NPU_D_OUT/FIFO_*/RD    core output FIFO head, flags and pop strobe
//   RES_*                  packed 32-bit result stream out (valid/ready, byte count, last)
//   BUSY, TIMEOUT_ERR      controller busy and sticky completion-timeout flag
//   JOB_CNT                completed job counter
module npu_job_ctrl #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic             CLKEXT,
    input  logic             RST_GLO,
    input  logic             JOB_VALID,
    output logic             JOB_READY,
    input  logic [31:0]      JOB_DATA,
    input  logic             JOB_LAST,
    output logic             NPU_START,
    output logic [7:0]       DA,
    output logic [7:0]       DB,
    output logic [7:0]       DC,
    output logic [7:0]       DD,
    input  logic             NPU_BUSY,
    input  logic             NPU_DONE,
    input  logic [7:0]       NPU_D_OUT,
    input  logic             NPU_FIFO_EMPTY,
    input  logic             NPU_FIFO_FULL,
    output logic             NPU_RD,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [31:0]      RES_DATA,
    output logic [2:0]       RES_BYTES,
    output logic             RES_LAST,
    output logic             BUSY,
    output logic             TIMEOUT_ERR,
    output logic [CNT_W-1:0] JOB_CNT
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, DRAIN, ERR} state_t;

    state_t        state, nxt;
    logic [TW-1:0] wcnt;
    logic          inflight;
    logic [31:0]   pk_data;
    logic [2:0]    pk_n;
    logic          accept, timeout, drain_idle, rel_full, rel_last, res_fire;

    // Packer doubles as the result register, so nothing moves while a word is offered.
    assign RES_DATA   = pk_data;
    assign RES_BYTES  = pk_n;
    assign BUSY       = state != IDLE;
    // Reset gating keeps every output low while RST_GLO is held.
    assign JOB_READY  = (state == IDLE || state == LOAD) && !NPU_FIFO_FULL && !RST_GLO;
    assign accept     = JOB_VALID && JOB_READY;
    assign timeout    = state == WAIT_DONE && !NPU_DONE && wcnt == TW'(TIMEOUT_CYC - 1);
    assign drain_idle = state == DRAIN && !RES_VALID && !inflight;
    assign NPU_RD     = drain_idle && !NPU_FIFO_EMPTY && pk_n != 3'd4;
    assign rel_full   = drain_idle && !NPU_FIFO_EMPTY && pk_n == 3'd4;
    assign rel_last   = drain_idle && NPU_FIFO_EMPTY;
    assign res_fire   = RES_VALID && RES_READY;

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) state <= IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = accept ? (JOB_LAST ? WAIT_DONE : LOAD) : IDLE;
            LOAD:      nxt = (accept && JOB_LAST) ? WAIT_DONE : LOAD;
            WAIT_DONE: nxt = NPU_DONE ? DRAIN : (timeout ? ERR : WAIT_DONE);
            DRAIN:     nxt = (res_fire && RES_LAST) ? IDLE : DRAIN;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            NPU_START   <= 1'b0;
            {DD, DC, DB, DA} <= '0;
            wcnt        <= '0;
            TIMEOUT_ERR <= 1'b0;
            inflight    <= 1'b0;
            pk_data     <= '0;
            pk_n        <= '0;
            RES_VALID   <= 1'b0;
            RES_LAST    <= 1'b0;
            JOB_CNT     <= '0;
        end else begin
            NPU_START <= state == IDLE && accept;
            if (accept) {DD, DC, DB, DA} <= JOB_DATA;
            wcnt <= state == WAIT_DONE ? wcnt + TW'(1) : '0;
            if (state == IDLE && accept) TIMEOUT_ERR <= 1'b0;
            else if (timeout)            TIMEOUT_ERR <= 1'b1;
            inflight <= NPU_RD;
            // Byte popped last cycle is on NPU_D_OUT now.
            if (inflight) begin
                pk_data[{pk_n[1:0], 3'b000} +: 8] <= NPU_D_OUT;
                pk_n <= pk_n + 3'd1;
            end
            if (rel_full || rel_last) begin
                RES_VALID <= 1'b1;
                RES_LAST  <= rel_last;
            end
            if (res_fire) begin
                RES_VALID <= 1'b0;
                RES_LAST  <= 1'b0;
                pk_data   <= '0;
                pk_n      <= '0;
                if (RES_LAST) JOB_CNT <= JOB_CNT + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_npu_job_ctrl.sv
// tb_npu_job_ctrl: directed self-checking bench for npu_job_ctrl with a small core FIFO model.
module tb_npu_job_ctrl;
    logic        CLKEXT = 1'b0, RST_GLO = 1'b1;
    logic        JOB_VALID = 1'b0, JOB_LAST = 1'b0, JOB_READY;
    logic [31:0] JOB_DATA = '0;
    logic        NPU_START, NPU_RD;
    logic [7:0]  DA, DB, DC, DD;
    logic        NPU_BUSY = 1'b0, NPU_DONE = 1'b0, NPU_FIFO_FULL = 1'b0, NPU_FIFO_EMPTY;
    logic [7:0]  dout = '0;
    logic        RES_VALID, RES_READY = 1'b0, RES_LAST, BUSY, TIMEOUT_ERR;
    logic [31:0] RES_DATA;
    logic [2:0]  RES_BYTES;
    logic [15:0] JOB_CNT;

    int total = 0, bad = 0;
    logic [7:0] fq [256];
    int fptr = 0, fcnt = 0;
    int cyc = 0, rd_cnt = 0, last_rd = -10, gap_bad = 0;

    npu_job_ctrl #(.TIMEOUT_CYC(16), .CNT_W(16)) dut (
        .CLKEXT(CLKEXT), .RST_GLO(RST_GLO),
        .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY), .JOB_DATA(JOB_DATA), .JOB_LAST(JOB_LAST),
        .NPU_START(NPU_START), .DA(DA), .DB(DB), .DC(DC), .DD(DD),
        .NPU_BUSY(NPU_BUSY), .NPU_DONE(NPU_DONE), .NPU_D_OUT(dout),
        .NPU_FIFO_EMPTY(NPU_FIFO_EMPTY), .NPU_FIFO_FULL(NPU_FIFO_FULL), .NPU_RD(NPU_RD),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
        .RES_BYTES(RES_BYTES), .RES_LAST(RES_LAST),
        .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .JOB_CNT(JOB_CNT)
    );

    always #5 CLKEXT = ~CLKEXT;

    assign NPU_FIFO_EMPTY = fptr >= fcnt;

    // Core output FIFO: a pop presents its byte on the following cycle.
    always @(posedge CLKEXT) begin
        cyc <= cyc + 1;
        if (NPU_RD) begin
            dout    <= fq[fptr];
            fptr    <= fptr + 1;
            rd_cnt  <= rd_cnt + 1;
            if (cyc - last_rd < 2) gap_bad <= gap_bad + 1;
            last_rd <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fq[fptr + i] = base + 8'(i);
        fcnt = fptr + n;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        JOB_VALID = 1'b1; JOB_DATA = d; JOB_LAST = l;
        for (int i = 0; i < 50 && !JOB_READY; i++) @(negedge CLKEXT);
        if (!JOB_READY) chk("send_wait", 32'd0, 32'd1);
        @(negedge CLKEXT);
        JOB_VALID = 1'b0;
    endtask

    task automatic done_pulse();
        NPU_DONE = 1'b1;
        @(negedge CLKEXT);
        NPU_DONE = 1'b0;
    endtask

    task automatic get_res(output logic [31:0] d, output logic [2:0] b, output logic l);
        d = '0; b = '0; l = 1'b0;
        for (int i = 0; i < 200 && !RES_VALID; i++) @(negedge CLKEXT);
        if (!RES_VALID) begin
            chk("res_wait", 32'd0, 32'd1);
            return;
        end
        d = RES_DATA; b = RES_BYTES; l = RES_LAST;
        RES_READY = 1'b1;
        @(negedge CLKEXT);
        RES_READY = 1'b0;
    endtask

    logic [31:0] d;
    logic [2:0]  b;
    logic        l, seen, stable;
    int          rd0;

    initial begin
        repeat (2) @(negedge CLKEXT);
        chk("rst_busy", BUSY, 0);
        chk("rst_cnt", JOB_CNT, 0);
        chk("rst_lane", {DD, DC, DB, DA}, 0);
        chk("rst_ready", JOB_READY, 0);
        chk("rst_err", TIMEOUT_ERR, 0);
        RST_GLO = 1'b0;
        @(negedge CLKEXT);
        chk("idle_ready", JOB_READY, 1);

        load(8'hA0, 3);
        send(32'h44332211, 1'b1);
        chk("t1_lanes", {DD, DC, DB, DA}, 32'h44332211);
        chk("t1_start", NPU_START, 1);
        chk("t1_busy", BUSY, 1);
        @(negedge CLKEXT);
        chk("t1_start_off", NPU_START, 0);
        done_pulse();
        get_res(d, b, l);
        chk("t1_data", d, 32'h00A2A1A0);
        chk("t1_bytes", b, 3);
        chk("t1_last", l, 1);
        chk("t1_cnt", JOB_CNT, 1);
        chk("t1_idle", BUSY, 0);

        load(8'h01, 8);
        rd0 = rd_cnt;
        send(32'h0000_0001, 1'b0);
        send(32'h0000_0002, 1'b0);
        send(32'h0000_0003, 1'b1);
        done_pulse();
        get_res(d, b, l);
        chk("t2_w0", d, 32'h04030201);
        chk("t2_b0", b, 4);
        chk("t2_l0", l, 0);
        get_res(d, b, l);
        chk("t2_w1", d, 32'h08070605);
        chk("t2_b1", b, 4);
        chk("t2_l1", l, 1);
        chk("t2_rds", rd_cnt - rd0, 8);
        chk("t2_gap", gap_bad, 0);
        chk("t2_cnt", JOB_CNT, 2);

        load(8'h10, 6);
        send(32'h0000_0010, 1'b1);
        done_pulse();
        for (int i = 0; i < 100 && !RES_VALID; i++) @(negedge CLKEXT);
        rd0 = rd_cnt;
        stable = 1'b1;
        repeat (10) begin
            @(negedge CLKEXT);
            if (RES_DATA !== 32'h13121110 || !RES_VALID) stable = 1'b0;
        end
        chk("t3_no_rd", rd_cnt - rd0, 0);
        chk("t3_stable", stable, 1);
        get_res(d, b, l);
        chk("t3_w0", d, 32'h13121110);
        get_res(d, b, l);
        chk("t3_w1", d, 32'h00001514);
        chk("t3_b1", b, 2);
        chk("t3_l1", l, 1);
        chk("t3_cnt", JOB_CNT, 3);

        seen = 1'b0;
        send(32'hAABBCCDD, 1'b1);
        repeat (15) begin
            @(negedge CLKEXT);
            if (RES_VALID) seen = 1'b1;
        end
        chk("t4_err_early", TIMEOUT_ERR, 0);
        chk("t4_wait_busy", BUSY, 1);
        @(negedge CLKEXT);
        chk("t4_err_set", TIMEOUT_ERR, 1);
        chk("t4_err_busy", BUSY, 1);
        @(negedge CLKEXT);
        chk("t4_idle", BUSY, 0);
        chk("t4_sticky", TIMEOUT_ERR, 1);
        chk("t4_no_res", seen | RES_VALID, 0);
        chk("t4_cnt", JOB_CNT, 3);

        fcnt = fptr;
        send(32'h01020304, 1'b1);
        chk("t5_err_clr", TIMEOUT_ERR, 0);
        done_pulse();
        get_res(d, b, l);
        chk("t5_data", d, 0);
        chk("t5_bytes", b, 0);
        chk("t5_last", l, 1);
        chk("t5_cnt", JOB_CNT, 4);

        send(32'h11111111, 1'b0);
        NPU_FIFO_FULL = 1'b1;
        JOB_VALID = 1'b1; JOB_DATA = 32'h22222222; JOB_LAST = 1'b0;
        #1;
        chk("t6_ready", JOB_READY, 0);
        repeat (3) @(negedge CLKEXT);
        chk("t6_hold", {DD, DC, DB, DA}, 32'h11111111);
        NPU_FIFO_FULL = 1'b0;
        send(32'h22222222, 1'b0);
        chk("t6_next", {DD, DC, DB, DA}, 32'h22222222);
        load(8'hC0, 5);
        send(32'h33333333, 1'b1);
        done_pulse();
        for (int i = 0; i < 100 && !RES_VALID; i++) @(negedge CLKEXT);
        chk("t7_pending", RES_VALID, 1);
        #2 RST_GLO = 1'b1;
        #1;
        chk("t7_valid", RES_VALID, 0);
        chk("t7_busy", BUSY, 0);
        chk("t7_lanes", {DD, DC, DB, DA}, 0);
        chk("t7_cnt", JOB_CNT, 0);
        chk("t7_data", RES_DATA, 0);
        chk("t7_rd_ready", {NPU_RD, JOB_READY, NPU_START}, 0);
        repeat (2) @(negedge CLKEXT);
        RST_GLO = 1'b0;
        fcnt = fptr;
        @(negedge CLKEXT);
        chk("t7_idle", BUSY, 0);
        load(8'h5A, 1);
        send(32'h00000099, 1'b1);
        chk("t7_start", NPU_START, 1);
        chk("t7_da", DA, 32'h99);
        done_pulse();
        get_res(d, b, l);
        chk("t7_res", d, 32'h0000005A);
        chk("t7_rb", b, 1);
        chk("t7_cnt_new", JOB_CNT, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1);
    end
endmodule
